// File: rtl/in_port_pkg.sv
// in_port_pkg: shared SAP-1 constants used by the input port.
package in_port_pkg;
  localparam int BUS_W = 8;
  localparam int CW_IN_EN = 10;  // control-word bit that selects the input port onto the bus
endpackage

// File: rtl/in_port_if.sv
// in_port_if: producer/CPU-side signals of the input port; master drives, slave (in_port) responds.
interface in_port_if import in_port_pkg::*; #(parameter int DEPTH = 4);
  logic mclk_en;
  logic i_wr_strobe;
  logic [BUS_W-1:0] i_wr_data;
  logic i_bus_enable;
  logic i_ovf_clear;
  logic [BUS_W-1:0] o_data;
  logic o_empty;
  logic o_full;
  logic [$clog2(DEPTH):0] o_count;
  logic o_overflow;
  modport master (
    output mclk_en, i_wr_strobe, i_wr_data, i_bus_enable, i_ovf_clear,
    input o_data, o_empty, o_full, o_count, o_overflow
  );
  modport slave (
    input mclk_en, i_wr_strobe, i_wr_data, i_bus_enable, i_ovf_clear,
    output o_data, o_empty, o_full, o_count, o_overflow
  );
endinterface

// File: rtl/in_port_sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0] count,
  output logic full,
  output logic empty,
  output logic wr_drop
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic push, pop;
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == CW'(DEPTH);
    pop = rd_en & ~empty;
    push = wr_en & (~full | pop);
    wr_drop = wr_en & ~push;
    rd_d = rd_q + AW'(pop);
    wr_d = wr_q + AW'(push);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    mem_d = mem_q;
    if (push) mem_d[wr_q] = wr_data;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign rd_data = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/in_port.sv
// in_port: SAP-1 input port FIFO read via the bus mux; IN_PORT_OVERFLOW_EN adds a sticky drop flag.
module in_port import in_port_pkg::*; #(parameter int DEPTH = 4) (
  input logic mclk,
  input logic rst,
  in_port_if.slave b
);
  logic [BUS_W-1:0] head;
  logic empty, drop;
  sync_fifo #(.WIDTH(BUS_W), .DEPTH(DEPTH)) u_fifo (
    .clk(mclk),
    .rst(rst),
    .wr_en(b.i_wr_strobe),
    .wr_data(b.i_wr_data),
    .rd_en(b.mclk_en & b.i_bus_enable),
    .rd_data(head),
    .count(b.o_count),
    .full(b.o_full),
    .empty(empty),
    .wr_drop(drop)
  );
  assign b.o_empty = empty;
  assign b.o_data = empty ? '0 : head;
`ifdef IN_PORT_OVERFLOW_EN
  logic ovf_q, ovf_d;
  always_comb ovf_d = drop | (ovf_q & ~b.i_ovf_clear);
  always_ff @(posedge mclk or posedge rst)
    if (rst) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  assign b.o_overflow = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = b.i_ovf_clear ^ drop;
  assign b.o_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_in_port.sv
// tb_in_port: randomized + directed scoreboard bench against a queue-based model of the input port.
module tb_in_port;
  localparam int D = 4;
  logic mclk = 1'b0;
  logic rst = 1'b1;
  always #5 mclk = ~mclk;
  in_port_if #(.DEPTH(D)) bi ();
  in_port #(.DEPTH(D)) dut (.mclk(mclk), .rst(rst), .b(bi));
  typedef struct {
    logic [7:0] data;
    int count;
    bit empty;
    bit full;
    bit ovf;
  } exp_t;
  exp_t exp_q[$];
  logic [7:0] fifo[$];
  bit ovf_m = 1'b0;
  int checks = 0;
  int errors = 0;
  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic cyc(bit st, logic [7:0] d, bit en, bit be, bit clr);
    bit rd, drop;
    exp_t e;
    @(negedge mclk);
    bi.i_wr_strobe = st;
    bi.i_wr_data = d;
    bi.mclk_en = en;
    bi.i_bus_enable = be;
    bi.i_ovf_clear = clr;
    rd = en && be && fifo.size() > 0;
    drop = st && fifo.size() == D && !rd;
    if (rd) void'(fifo.pop_front());
    if (st && !drop) fifo.push_back(d);
`ifdef IN_PORT_OVERFLOW_EN
    ovf_m = drop ? 1'b1 : (clr ? 1'b0 : ovf_m);
`endif
    e.data = fifo.size() > 0 ? fifo[0] : 8'h00;
    e.count = fifo.size();
    e.empty = fifo.size() == 0;
    e.full = fifo.size() == D;
    e.ovf = ovf_m;
    exp_q.push_back(e);
  endtask
  always @(posedge mclk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("data", int'(bi.o_data), int'(e.data));
      chk("count", int'(bi.o_count), e.count);
      chk("empty", int'(bi.o_empty), int'(e.empty));
      chk("full", int'(bi.o_full), int'(e.full));
      chk("overflow", int'(bi.o_overflow), int'(e.ovf));
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
  initial begin
    bi.i_wr_strobe = 0;
    bi.i_wr_data = '0;
    bi.mclk_en = 0;
    bi.i_bus_enable = 0;
    bi.i_ovf_clear = 0;
    repeat (2) @(negedge mclk);
    chk("rst_empty", int'(bi.o_empty), 1);
    chk("rst_count", int'(bi.o_count), 0);
    chk("rst_data", int'(bi.o_data), 0);
    chk("rst_ovf", int'(bi.o_overflow), 0);
    rst = 1'b0;
    cyc(0, 8'h00, 1, 1, 0);
    cyc(1, 8'h12, 0, 0, 0);
    cyc(1, 8'h34, 0, 0, 0);
    cyc(0, 8'h00, 1, 1, 0);
    cyc(0, 8'h00, 1, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 8'hA0 + 8'(i), 0, 0, 0);
    cyc(1, 8'hFF, 0, 0, 0);
    cyc(1, 8'h55, 1, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 1, 0);
    cyc(1, 8'h77, 1, 1, 0);
    cyc(1, 8'h88, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 0, 1, 0);
    cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 1, 1, 0);
    cyc(0, 8'h00, 1, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 8'hC0 + 8'(i), 0, 0, 0);
    cyc(1, 8'hEE, 0, 0, 0);
    cyc(0, 8'h00, 1, 1, 0);
    @(negedge mclk);
    bi.i_wr_strobe = 0;
    bi.mclk_en = 0;
    bi.i_bus_enable = 0;
    rst = 1'b1;
    #1;
    chk("async_rst_count", int'(bi.o_count), 0);
    chk("async_rst_ovf", int'(bi.o_overflow), 0);
    chk("async_rst_empty", int'(bi.o_empty), 1);
    chk("async_rst_data", int'(bi.o_data), 0);
    fifo.delete();
    ovf_m = 1'b0;
    @(negedge mclk);
    rst = 1'b0;
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
    repeat (2) @(negedge mclk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
